cache_mem_responder: RTL

CACHE_MEM_RESPONDER -- requirements
Module: cache_mem_responder

---
 rtl/cache_bus_pkg.sv | 34 +++
 rtl/cache_mem_responder.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/cache_bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cache_bus_pkg
//  Description : Shared type codes, line size and responder state encodings
//                for the cache <-> memory request bus.
//  Revision    : 1.0  initial release
// ============================================================================
package cache_bus_pkg;

  // Access type codes carried on rd_type / wr_type
  localparam logic [2:0] TYPE_BYTE = 3'b000;
  localparam logic [2:0] TYPE_HALF = 3'b001;
  localparam logic [2:0] TYPE_WORD = 3'b010;
  localparam logic [2:0] TYPE_LINE = 3'b100;

  // Words per cache line
  localparam int LINE_BEATS = 4;

  // Responder states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD     = 2'd1,
    RD_END = 2'd2,
    WR     = 2'd3
  } state_t;

  // Index of the final beat: a line moves LINE_BEATS words, every other code
  // (including unsupported ones) moves a single word.
  function automatic logic [1:0] last_beat(input logic [2:0] t);
    return (t == TYPE_LINE) ? 2'(LINE_BEATS - 1) : 2'd0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cache_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : cache_mem_responder
//  Description : Serves cache read/write requests (byte/half/word/line) from
//                an external single-port synchronous SRAM, one word per cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module cache_mem_responder
  import cache_bus_pkg::*;
#(
  parameter int SRAM_AW = 14
) (
  input  logic               clk,
  input  logic               resetn,
  // read request / return
  input  logic               rd_req,
  input  logic [2:0]         rd_type,
  input  logic [31:0]        rd_addr,
  output logic               rd_rdy,
  output logic               ret_valid,
  output logic               ret_last,
  output logic [31:0]        ret_data,
  // write request
  input  logic               wr_req,
  input  logic [2:0]         wr_type,
  input  logic [31:0]        wr_addr,
  input  logic [3:0]         wr_wstrb,
  input  logic [127:0]       wr_data,
  output logic               wr_rdy,
  // SRAM port
  output logic               sram_en,
  output logic [3:0]         sram_we,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [31:0]        sram_wdata,
  input  logic [31:0]        sram_rdata
);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [1:0]           r_cnt;
  logic [1:0]           w_cnt_nxt;
  logic [1:0]           r_last;
  logic [SRAM_AW-1:0]   r_base;
  logic [3:0]           r_wstrb;
  logic [127:0]         r_wdata;
  logic                 r_ret_valid;
  logic                 r_ret_last;
  logic                 w_rd_acc;
  logic                 w_wr_acc;

  // Byte-offset bits and bits above the SRAM size play no part in addressing;
  // accesses simply wrap modulo the SRAM size.
  logic w_unused_addr_bits;
  assign w_unused_addr_bits = ^{rd_addr[31:SRAM_AW+2], rd_addr[1:0],
                                wr_addr[31:SRAM_AW+2], wr_addr[1:0]};

  // Word address of the first beat; lines start on a 4-word boundary.
  function automatic logic [SRAM_AW-1:0] base_of(input logic [31:0] a,
                                                 input logic [2:0]  t);
    logic [SRAM_AW-1:0] w;
    w = a[SRAM_AW+1:2];
    if (t == TYPE_LINE) w[1:0] = 2'b00;
    return w;
  endfunction

  // State and beat counter register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_cnt   <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state, handshake and SRAM control decode
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_rd_acc    = 1'b0;
    w_wr_acc    = 1'b0;
    rd_rdy      = 1'b0;
    wr_rdy      = 1'b0;
    sram_en     = 1'b0;
    sram_we     = 4'h0;
    case (r_state)
      IDLE: begin
        // Ready flags are qualified with resetn so they read 0 while the
        // block is held in reset even though the state already shows IDLE.
        wr_rdy = resetn;
        rd_rdy = resetn & ~wr_req;
        if (wr_req) begin
          w_wr_acc    = 1'b1;
          w_state_nxt = WR;
        end else if (rd_req) begin
          w_rd_acc    = 1'b1;
          w_state_nxt = RD;
        end
      end
      RD: begin
        sram_en = 1'b1;
        if (r_cnt == r_last) begin
          w_state_nxt = RD_END;
          w_cnt_nxt   = 2'd0;
        end else begin
          w_cnt_nxt   = r_cnt + 2'd1;
        end
      end
      RD_END: begin
        w_state_nxt = IDLE;
      end
      WR: begin
        sram_en = 1'b1;
        sram_we = r_wstrb;
        if (r_cnt == r_last) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = 2'd0;
        end else begin
          w_cnt_nxt   = r_cnt + 2'd1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = 2'd0;
      end
    endcase
  end

  // Capture the accepted request so the requester may change its inputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_last  <= 2'd0;
      r_base  <= '0;
      r_wstrb <= 4'h0;
      r_wdata <= '0;
    end else if (w_wr_acc) begin
      r_last  <= last_beat(wr_type);
      r_base  <= base_of(wr_addr, wr_type);
      r_wstrb <= wr_wstrb;
      r_wdata <= wr_data;
    end else if (w_rd_acc) begin
      r_last  <= last_beat(rd_type);
      r_base  <= base_of(rd_addr, rd_type);
    end
  end

  // Return beat flags trail the SRAM read issue by one cycle (SRAM latency)
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ret_valid <= 1'b0;
      r_ret_last  <= 1'b0;
    end else begin
      r_ret_valid <= (r_state == RD);
      r_ret_last  <= (r_state == RD) && (r_cnt == r_last);
    end
  end

  // Base is line-aligned whenever the counter is non-zero, so OR-ing the
  // counter into the low bits selects the current word.
  assign sram_addr  = {r_base[SRAM_AW-1:2], r_base[1:0] | r_cnt};
  assign sram_wdata = r_wdata[{r_cnt, 5'b00000} +: 32];

  assign ret_valid  = r_ret_valid;
  assign ret_last   = r_ret_last;
  assign ret_data   = r_ret_valid ? sram_rdata : 32'h0;

endmodule
`default_nettype wire
